hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline; sits beside the ID/EX/MEM/WB pipeline registers.
- Generates ALU operand forward selects (fwd_a/fwd_b) and the store-data select (memsrc) for the MEM-stage write-data mux.
- Sequences load-use stalls and taken-branch flushes through a small FSM; keeps saturating stall/flush event counters for debug.

Parameters:
FLUSH_CYC, 1, cycles of IF/ID+ID/EX flush per taken branch (1..7)
CNT_W, 16, width of event counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
if_id_rs  in  5  rs of instr in ID
if_id_rt  in  5  rt of instr in ID
if_id_uses_rt  in  1  ID instr reads rt as ALU source
if_id_is_store  in  1  ID instr is sw (rt = store data)
id_ex_rs  in  5  rs in EX
id_ex_rt  in  5  rt in EX
id_ex_memread  in  1  EX instr is a load
ex_mem_rd  in  5  dest reg in MEM
ex_mem_regwrite  in  1  MEM instr writes reg
ex_mem_rt  in  5  store-data reg of MEM instr
ex_mem_memwrite  in  1  MEM instr is a store
mem_wb_rd  in  5  dest reg in WB
mem_wb_regwrite  in  1  WB instr writes reg
mem_wb_memtoreg  in  1  WB result comes from memory
branch_taken  in  1  branch resolved taken this cycle
fwd_a  out  2  EX operand A select
fwd_b  out  2  EX operand B select
memsrc  out  2  store write-data select
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  zero IF/ID
id_ex_flush  out  1  insert bubble in ID/EX
stall_cnt  out  CNT_W  load-use stall cycles (saturating)
flush_cnt  out  CNT_W  flush cycles (saturating)

Behaviour:
- Forwarding is combinational, valid every cycle in every state. A match requires dest != 0.
- fwd_a/fwd_b: 2'b10 when ex_mem_regwrite and ex_mem_rd == id_ex_rs/rt. Else 2'b01 when mem_wb_regwrite and mem_wb_rd == id_ex_rs/rt. Else 2'b00. EX/MEM has priority.
- memsrc: 2'b00 by default. When ex_mem_memwrite, mem_wb_regwrite and mem_wb_rd == ex_mem_rt (nonzero): 2'b01 if mem_wb_memtoreg (load data), else 2'b10 (ALU result). 2'b11 is never driven.
- load_use = id_ex_memread & id_ex_rt != 0 & (id_ex_rt == if_id_rs | (id_ex_rt == if_id_rt & if_id_uses_rt & !if_id_is_store)). A store whose data reg is the load target does not stall; memsrc = 01 covers it.
- Default outputs: pc_write=1, if_id_write=1, flushes=0.
- FSM states: RUN, STALL, FLUSH; 3-bit down-counter fcnt.
- RUN, branch_taken: assert if_id_flush=1 and id_ex_flush=1 this cycle. If FLUSH_CYC > 1, go to FLUSH with fcnt = FLUSH_CYC-2; else stay in RUN.
- RUN, load_use and !branch_taken: assert pc_write=0, if_id_write=0, id_ex_flush=1 this cycle, then go to STALL.
- branch_taken beats load_use when both occur in the same cycle.
- STALL: one cycle, default outputs, load_use detection suppressed (EX holds the bubble). Next state is RUN. branch_taken in STALL behaves as in RUN, including the transition to FLUSH.
- FLUSH: if_id_flush=1, id_ex_flush=1, pc_write=1. fcnt decrements each cycle; exit to RUN when fcnt == 0. branch_taken and load_use are ignored (wrong path).
- stall_cnt increments on every cycle with the load-use stall asserted; flush_cnt increments on every cycle with if_id_flush=1. Both saturate at all-ones.
- Reset (rst_n=0 at clk edge), including mid-STALL/FLUSH: state=RUN, fcnt=0, counters=0.
- During reset, control outputs take their combinational RUN/default values: pc_write=1, if_id_write=1, flushes=0, fwd/memsrc per inputs.

Test Plan:
- lw $2 in EX, add using $2 (rs) in ID -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; then STALL; stall_cnt=1; next cycle fwd_a=01 (MEM/WB).
- lw $2 in EX, sw $2 in ID (rt only) -> no stall. Two cycles later, sw in MEM with lw in WB -> memsrc=01. Same with add $2 in WB -> memsrc=10.
- ex_mem_rd = mem_wb_rd = $5 = id_ex_rs, both regwrite -> fwd_a=10. Rd=$0 in both -> fwd_a=00.
- FLUSH_CYC=3, branch_taken pulse -> if_id_flush/id_ex_flush high exactly 3 cycles, flush_cnt=3. Second branch_taken during FLUSH is ignored.
- branch_taken and load_use in the same cycle -> flush path taken, pc_write=1, stall_cnt unchanged.
- rst_n low during FLUSH cycle 2 -> next cycle RUN, flushes 0, counters 0. Preload near saturation -> counter holds at 0xFFFF.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl
// Description : Hazard and forwarding controller for a 5-stage MIPS pipeline.
//               Produces the EX operand forward selects and the MEM-stage
//               store-data select. Sequences load-use stalls and taken-branch
//               flushes with a RUN/STALL/FLUSH FSM, and keeps saturating
//               debug counters of stall and flush cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   if_id_*             source regs / usage flags of the instruction in ID
//   id_ex_*             source regs / load flag of the instruction in EX
//   ex_mem_*            dest reg, regwrite, store-data reg, store flag in MEM
//   mem_wb_*            dest reg, regwrite, memtoreg flag in WB
//   branch_taken        branch resolved taken this cycle
//   fwd_a, fwd_b        EX operand selects: 10 = EX/MEM, 01 = MEM/WB, 00 = RF
//   memsrc              store data select: 01 = WB load data, 10 = WB ALU
//   pc_write            PC update enable
//   if_id_write         IF/ID load enable
//   if_id_flush         zero IF/ID
//   id_ex_flush         insert bubble into ID/EX
//   stall_cnt           saturating count of load-use stall cycles
//   flush_cnt           saturating count of flush cycles
// ============================================================================
module hazard_forward_ctrl #(
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             if_id_is_store,
  input  logic [4:0]       id_ex_rs,
  input  logic [4:0]       id_ex_rt,
  input  logic             id_ex_memread,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_regwrite,
  input  logic [4:0]       ex_mem_rt,
  input  logic             ex_mem_memwrite,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_regwrite,
  input  logic             mem_wb_memtoreg,
  input  logic             branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       memsrc,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // The branch cycle itself is the first flush cycle, so FLUSH holds for
  // FLUSH_CYC-1 cycles: fcnt is loaded with FLUSH_CYC-2 and exits at zero.
  localparam bit       MULTI_FLUSH = (FLUSH_CYC > 1);
  localparam int       FCNT_INIT_I = MULTI_FLUSH ? (FLUSH_CYC - 2) : 0;
  localparam logic [2:0] FCNT_INIT = FCNT_INIT_I[2:0];

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [2:0] fcnt;
  logic [2:0] fcnt_nxt;

  logic ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b, wb_hit_st;
  logic load_use;
  logic stall_evt;

  // --------------------------------------------------------------------------
  // Forwarding: purely combinational, independent of FSM state.
  // --------------------------------------------------------------------------
  always_comb begin
    ex_hit_a  = ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_rs);
    ex_hit_b  = ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_rt);
    wb_hit_a  = mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs);
    wb_hit_b  = mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rt);
    wb_hit_st = ex_mem_memwrite && mem_wb_regwrite && (mem_wb_rd != 5'd0)
                && (mem_wb_rd == ex_mem_rt);

    fwd_a = ex_hit_a ? 2'b10 : (wb_hit_a ? 2'b01 : 2'b00);
    fwd_b = ex_hit_b ? 2'b10 : (wb_hit_b ? 2'b01 : 2'b00);

    memsrc = 2'b00;
    if (wb_hit_st) begin
      memsrc = mem_wb_memtoreg ? 2'b01 : 2'b10;
    end

    // A store only reads rt as data; that case is covered by memsrc later.
    load_use = id_ex_memread && (id_ex_rt != 5'd0)
               && ((id_ex_rt == if_id_rs)
                   || ((id_ex_rt == if_id_rt) && if_id_uses_rt && !if_id_is_store));
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = ST_RUN;
    fcnt_nxt  = fcnt;
    case (state)
      ST_RUN, ST_STALL: begin
        if (branch_taken) begin
          if (MULTI_FLUSH) begin
            state_nxt = ST_FLUSH;
            fcnt_nxt  = FCNT_INIT;
          end
        end else if ((state == ST_RUN) && load_use) begin
          state_nxt = ST_STALL;
        end
      end
      ST_FLUSH: begin
        if (fcnt != 3'd0) begin
          state_nxt = ST_FLUSH;
          fcnt_nxt  = fcnt - 3'd1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. While reset is asserted the defaults are forced so the
  // pipeline sees a clean RUN view regardless of the stale state register.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    stall_evt   = 1'b0;
    if (rst_n) begin
      case (state)
        ST_RUN, ST_STALL: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if ((state == ST_RUN) && load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_evt   = 1'b1;
          end
        end
        ST_FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating debug counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (if_id_flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_ctrl
// Description : Scoreboard bench for hazard_forward_ctrl. Two instances share
//               one stimulus stream: FLUSH_CYC=3/CNT_W=16 and FLUSH_CYC=1/
//               CNT_W=4 (the narrow one makes counter saturation reachable).
//               A behavioural model tracks "flush cycles left" and "just
//               stalled" per instance and pushes expectations into a queue;
//               a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [4:0] if_rs, if_rt;
    logic       uses_rt, is_store;
    logic [4:0] ex_rs, ex_rt;
    logic       memread;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] mem_rt;
    logic       mem_mw;
    logic [4:0] wb_rd;
    logic       wb_rw, wb_m2r, br;
  } stim_t;

  typedef struct {
    logic [1:0]  fa, fb, ms;
    logic [3:0]  c0, c1;      // {pc_write, if_id_write, if_id_flush, id_ex_flush}
    int unsigned s0, s1, f0, f1;
  } exp_t;

  // DUT inputs
  logic       rst_n = 1'b0;
  logic [4:0] if_id_rs = '0, if_id_rt = '0;
  logic       if_id_uses_rt = 1'b0, if_id_is_store = 1'b0;
  logic [4:0] id_ex_rs = '0, id_ex_rt = '0;
  logic       id_ex_memread = 1'b0;
  logic [4:0] ex_mem_rd = '0;
  logic       ex_mem_regwrite = 1'b0;
  logic [4:0] ex_mem_rt = '0;
  logic       ex_mem_memwrite = 1'b0;
  logic [4:0] mem_wb_rd = '0;
  logic       mem_wb_regwrite = 1'b0, mem_wb_memtoreg = 1'b0;
  logic       branch_taken = 1'b0;

  // DUT outputs
  logic [1:0]  fwd_a0, fwd_b0, memsrc0, fwd_a1, fwd_b1, memsrc1;
  logic        pcw0, ifw0, iff0, ief0, pcw1, ifw1, iff1, ief1;
  logic [15:0] stall_cnt0, flush_cnt0;
  logic [3:0]  stall_cnt1, flush_cnt1;

  hazard_forward_ctrl #(.FLUSH_CYC(3), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .if_id_is_store(if_id_is_store),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_memread(id_ex_memread),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .ex_mem_rt(ex_mem_rt), .ex_mem_memwrite(ex_mem_memwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_memtoreg(mem_wb_memtoreg), .branch_taken(branch_taken),
    .fwd_a(fwd_a0), .fwd_b(fwd_b0), .memsrc(memsrc0),
    .pc_write(pcw0), .if_id_write(ifw0), .if_id_flush(iff0), .id_ex_flush(ief0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  hazard_forward_ctrl #(.FLUSH_CYC(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .if_id_is_store(if_id_is_store),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_memread(id_ex_memread),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .ex_mem_rt(ex_mem_rt), .ex_mem_memwrite(ex_mem_memwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_memtoreg(mem_wb_memtoreg), .branch_taken(branch_taken),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .memsrc(memsrc1),
    .pc_write(pcw1), .if_id_write(ifw1), .if_id_flush(iff1), .id_ex_flush(ief1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  // --------------------------------------------------------------------------
  // Reference model state (per instance)
  // --------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb_q[$];
  int          fcyc[2]     = '{3, 1};
  int unsigned cmax[2]     = '{65535, 15};
  int          flush_left[2];
  bit          in_stall[2];
  int unsigned sc[2], fc[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, default: '0};
    return s;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input stim_t s);
    if (s.mem_rw && s.mem_rd != 0 && s.mem_rd == src) return 2'b10;
    if (s.wb_rw && s.wb_rd != 0 && s.wb_rd == src)    return 2'b01;
    return 2'b00;
  endfunction

  // Advance one instance's model; returns this cycle's control vector.
  function automatic logic [3:0] model_ctrl(input int d, input stim_t s);
    bit lu, stall, flush;
    lu = s.memread && s.ex_rt != 0 &&
         (s.ex_rt == s.if_rs || (s.ex_rt == s.if_rt && s.uses_rt && !s.is_store));
    stall = 0;
    flush = 0;
    if (!s.rst_n) begin
      flush_left[d] = 0;
      in_stall[d]   = 0;
      sc[d] = 0;
      fc[d] = 0;
      return 4'b1100;
    end
    if (flush_left[d] > 0) begin
      flush = 1;
      flush_left[d]--;
      in_stall[d] = 0;
    end else if (s.br) begin
      flush = 1;
      flush_left[d] = fcyc[d] - 1;
      in_stall[d] = 0;
    end else if (!in_stall[d] && lu) begin
      stall = 1;
      in_stall[d] = 1;
    end else begin
      in_stall[d] = 0;
    end
    if (stall && sc[d] < cmax[d]) sc[d]++;
    if (flush && fc[d] < cmax[d]) fc[d]++;
    return {~stall, ~stall, flush, flush | stall};
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = s.rst_n;
    if_id_rs = s.if_rs; if_id_rt = s.if_rt;
    if_id_uses_rt = s.uses_rt; if_id_is_store = s.is_store;
    id_ex_rs = s.ex_rs; id_ex_rt = s.ex_rt; id_ex_memread = s.memread;
    ex_mem_rd = s.mem_rd; ex_mem_regwrite = s.mem_rw;
    ex_mem_rt = s.mem_rt; ex_mem_memwrite = s.mem_mw;
    mem_wb_rd = s.wb_rd; mem_wb_regwrite = s.wb_rw; mem_wb_memtoreg = s.wb_m2r;
    branch_taken = s.br;

    e.fa = fwd_sel(s.ex_rs, s);
    e.fb = fwd_sel(s.ex_rt, s);
    e.ms = 2'b00;
    if (s.mem_mw && s.wb_rw && s.wb_rd != 0 && s.wb_rd == s.mem_rt)
      e.ms = s.wb_m2r ? 2'b01 : 2'b10;
    // Counters shown this cycle are the values before this cycle's update.
    e.s0 = sc[0]; e.f0 = fc[0]; e.s1 = sc[1]; e.f1 = fc[1];
    e.c0 = model_ctrl(0, s);
    e.c1 = model_ctrl(1, s);
    sb_q.push_back(e);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst_n    = ($urandom_range(0, 99) >= 2);
    s.if_rs    = 5'($urandom_range(0, 3));
    s.if_rt    = 5'($urandom_range(0, 3));
    s.uses_rt  = 1'($urandom);
    s.is_store = 1'($urandom);
    s.ex_rs    = 5'($urandom_range(0, 3));
    s.ex_rt    = 5'($urandom_range(0, 3));
    s.memread  = 1'($urandom);
    s.mem_rd   = 5'($urandom_range(0, 3));
    s.mem_rw   = 1'($urandom);
    s.mem_rt   = 5'($urandom_range(0, 3));
    s.mem_mw   = 1'($urandom);
    s.wb_rd    = 5'($urandom_range(0, 3));
    s.wb_rw    = 1'($urandom);
    s.wb_m2r   = 1'($urandom);
    s.br       = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: combinational outputs are valid every cycle, compare mid-cycle.
  // --------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("fwd_a0",  32'(fwd_a0),  32'(e.fa));
        chk("fwd_b0",  32'(fwd_b0),  32'(e.fb));
        chk("memsrc0", 32'(memsrc0), 32'(e.ms));
        chk("fwd_a1",  32'(fwd_a1),  32'(e.fa));
        chk("fwd_b1",  32'(fwd_b1),  32'(e.fb));
        chk("memsrc1", 32'(memsrc1), 32'(e.ms));
        chk("ctrl0",   32'({pcw0, ifw0, iff0, ief0}), 32'(e.c0));
        chk("ctrl1",   32'({pcw1, ifw1, iff1, ief1}), 32'(e.c1));
        chk("stall_cnt0", 32'(stall_cnt0), e.s0);
        chk("flush_cnt0", 32'(flush_cnt0), e.f0);
        chk("stall_cnt1", 32'(stall_cnt1), e.s1);
        chk("flush_cnt1", 32'(flush_cnt1), e.f1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    stim_t s;
    for (int i = 0; i < 2; i++) begin
      flush_left[i] = 0; in_stall[i] = 0; sc[i] = 0; fc[i] = 0;
    end

    // Reset
    s = idle(); s.rst_n = 1'b0;
    repeat (3) step(s);

    // Load-use: lw $2 in EX, add reading $2 (rs) in ID
    s = idle(); s.memread = 1; s.ex_rt = 2; s.if_rs = 2; step(s);
    s = idle(); s.mem_rd = 2; s.mem_rw = 1; step(s);               // bubble in EX
    s = idle(); s.ex_rs = 2; s.wb_rd = 2; s.wb_rw = 1; s.wb_m2r = 1; step(s);

    // lw $2 in EX, sw $2 in ID: no stall; later store data from WB
    s = idle(); s.memread = 1; s.ex_rt = 2; s.if_rt = 2; s.if_rs = 3;
    s.uses_rt = 1; s.is_store = 1; step(s);
    s = idle(); s.mem_mw = 1; s.mem_rt = 2; s.wb_rd = 2; s.wb_rw = 1; s.wb_m2r = 1; step(s);
    s.wb_m2r = 0; step(s);

    // Forward priority and $0 suppression
    s = idle(); s.mem_rd = 5; s.mem_rw = 1; s.wb_rd = 5; s.wb_rw = 1; s.ex_rs = 5; step(s);
    s = idle(); s.mem_rw = 1; s.wb_rw = 1; step(s);

    // Branch pulse, second branch inside FLUSH ignored
    s = idle(); s.br = 1; step(s);
    s = idle(); step(s);
    s = idle(); s.br = 1; step(s);
    s = idle(); repeat (3) step(s);

    // Branch and load-use together
    s = idle(); s.br = 1; s.memread = 1; s.ex_rt = 2; s.if_rs = 2; step(s);
    s = idle(); repeat (3) step(s);

    // Reset during FLUSH cycle 2
    s = idle(); s.br = 1; step(s);
    s = idle(); s.rst_n = 0; step(s);
    s = idle(); repeat (3) step(s);

    // Randomized traffic
    repeat (3000) step(rand_stim());

    // Drive counters into saturation on the narrow instance
    s = idle(); s.br = 1; repeat (20) step(s);
    s = idle(); s.memread = 1; s.ex_rt = 3; s.if_rs = 3; repeat (40) step(s);
    s = idle(); repeat (2) step(s);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
